// File: rtl/enigma_key_seq_pkg.sv
// Shared types and constants for the Enigma keystroke sequencer.
// Stage codes select which substitution the shared datapath performs.
package enigma_key_seq_pkg;

  localparam int LETTER_W    = 5;
  localparam int NUM_LETTERS = 26;
  localparam int NOTCH1_DEF  = 17;
  localparam int NOTCH2_DEF  = 5;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STEP  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] STG_R1_FWD = 3'd0;
  localparam logic [2:0] STG_R2_FWD = 3'd1;
  localparam logic [2:0] STG_R3_FWD = 3'd2;
  localparam logic [2:0] STG_REFL   = 3'd3;
  localparam logic [2:0] STG_R3_INV = 3'd4;
  localparam logic [2:0] STG_R2_INV = 3'd5;
  localparam logic [2:0] STG_R1_INV = 3'd6;

  function automatic logic is_legal(input letter_t l);
    return (l != '0) && (l <= letter_t'(NUM_LETTERS));
  endfunction

  function automatic letter_t step_pos(input letter_t p);
    return (p == letter_t'(NUM_LETTERS)) ? letter_t'(1) : p + letter_t'(1);
  endfunction

endpackage

// File: rtl/enigma_key_seq_odometer.sv
// Rotor position odometer: load, single step with double-step anomaly, 26->1 wrap.
// The *_nxt outputs expose the positions that will be visible next cycle.
module enigma_odometer
  import enigma_key_seq_pkg::*;
#(
  parameter int NOTCH1 = NOTCH1_DEF,
  parameter int NOTCH2 = NOTCH2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic                step_en,
  input  logic [LETTER_W-1:0] pos1_in,
  input  logic [LETTER_W-1:0] pos2_in,
  input  logic [LETTER_W-1:0] pos3_in,
  output logic [LETTER_W-1:0] pos1,
  output logic [LETTER_W-1:0] pos2,
  output logic [LETTER_W-1:0] pos3,
  output logic [LETTER_W-1:0] pos1_nxt,
  output logic [LETTER_W-1:0] pos2_nxt,
  output logic [LETTER_W-1:0] pos3_nxt
);

  localparam letter_t N1 = letter_t'(NOTCH1);
  localparam letter_t N2 = letter_t'(NOTCH2);

  letter_t pos1_q, pos2_q, pos3_q;
  letter_t pos1_d, pos2_d, pos3_d;

  always_comb begin
    pos1_d = pos1_q;
    pos2_d = pos2_q;
    pos3_d = pos3_q;
    if (load_en) begin
      // Out-of-range start positions fall back to 1 so a position is never 0.
      pos1_d = is_legal(pos1_in) ? pos1_in : letter_t'(1);
      pos2_d = is_legal(pos2_in) ? pos2_in : letter_t'(1);
      pos3_d = is_legal(pos3_in) ? pos3_in : letter_t'(1);
    end else if (step_en) begin
      pos1_d = step_pos(pos1_q);
      if ((pos1_q == N1) || (pos2_q == N2)) pos2_d = step_pos(pos2_q);
      if (pos2_q == N2) pos3_d = step_pos(pos3_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos1_q <= letter_t'(1);
      pos2_q <= letter_t'(1);
      pos3_q <= letter_t'(1);
    end else begin
      pos1_q <= pos1_d;
      pos2_q <= pos2_d;
      pos3_q <= pos3_d;
    end
  end

  assign pos1     = pos1_q;
  assign pos2     = pos2_q;
  assign pos3     = pos3_q;
  assign pos1_nxt = pos1_d;
  assign pos2_nxt = pos2_d;
  assign pos3_nxt = pos3_d;

endmodule

// File: rtl/enigma_key_seq.sv
// Enigma keystroke sequencer: steps rotors, then walks seven substitution stages
// through a shared datapath; one key in flight, 16-cycle legal-key latency.
module enigma_key_seq
  import enigma_key_seq_pkg::*;
#(
  parameter int NOTCH1 = NOTCH1_DEF,
  parameter int NOTCH2 = NOTCH2_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  input  logic [LETTER_W-1:0] key_in,
  output logic                key_ready,
  input  logic                mode,
  input  logic                pos_load,
  input  logic [LETTER_W-1:0] pos1_in,
  input  logic [LETTER_W-1:0] pos2_in,
  input  logic [LETTER_W-1:0] pos3_in,
  output logic [2:0]          sub_sel,
  output logic [LETTER_W-1:0] sub_in,
  output logic [LETTER_W-1:0] sub_off,
  output logic                sub_strobe,
  input  logic [LETTER_W-1:0] sub_out,
  output logic                out_valid,
  output logic [LETTER_W-1:0] out_letter,
  input  logic                out_ready,
  output logic                err,
  output logic [LETTER_W-1:0] pos1,
  output logic [LETTER_W-1:0] pos2,
  output logic [LETTER_W-1:0] pos3,
  output logic [5:0]          key_cnt
);

  state_e     state_q, state_d;
  logic [2:0] stage_q, stage_d;
  letter_t    letter_q, letter_d;
  logic       fault_q, fault_d;
  logic       err_q, err_d;
  logic [5:0] key_cnt_q, key_cnt_d;
  letter_t    out_letter_q, out_letter_d;
  logic [2:0] sub_sel_q, sub_sel_d;
  letter_t    sub_in_q, sub_in_d;
  letter_t    sub_off_q, sub_off_d;

  letter_t    pos1_nxt, pos2_nxt, pos3_nxt;
  logic       load_en, step_en;

  assign key_ready  = (state_q == ST_IDLE) && !pos_load;
  assign load_en    = (state_q == ST_IDLE) && pos_load;
  assign step_en    = (state_q == ST_STEP) && !mode;
  assign sub_strobe = (state_q == ST_ISSUE);
  assign out_valid  = (state_q == ST_DONE);

  enigma_odometer #(
    .NOTCH1 (NOTCH1),
    .NOTCH2 (NOTCH2)
  ) u_odometer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (load_en),
    .step_en  (step_en),
    .pos1_in  (pos1_in),
    .pos2_in  (pos2_in),
    .pos3_in  (pos3_in),
    .pos1     (pos1),
    .pos2     (pos2),
    .pos3     (pos3),
    .pos1_nxt (pos1_nxt),
    .pos2_nxt (pos2_nxt),
    .pos3_nxt (pos3_nxt)
  );

  // Offsets use next-cycle positions so the STEP->ISSUE edge sees post-step values.
  function automatic letter_t stage_off(input logic [2:0] stg, input letter_t p1,
                                        input letter_t p2, input letter_t p3);
    case (stg)
      STG_R1_FWD, STG_R1_INV: return p1;
      STG_R2_FWD, STG_R2_INV: return p2;
      STG_R3_FWD, STG_R3_INV: return p3;
      default:                return '0;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    stage_d      = stage_q;
    letter_d     = letter_q;
    fault_d      = fault_q;
    err_d        = err_q;
    key_cnt_d    = key_cnt_q;
    out_letter_d = out_letter_q;
    sub_sel_d    = sub_sel_q;
    sub_in_d     = sub_in_q;
    sub_off_d    = sub_off_q;

    case (state_q)
      ST_IDLE: begin
        if (key_valid && key_ready) begin
          key_cnt_d = key_cnt_q + 6'd1;
          letter_d  = key_in;
          fault_d   = 1'b0;
          if (is_legal(key_in)) begin
            state_d = ST_STEP;
          end else begin
            state_d      = ST_DONE;
            out_letter_d = '0;
          end
        end
      end
      ST_STEP: begin
        state_d   = ST_ISSUE;
        stage_d   = STG_R1_FWD;
        sub_sel_d = STG_R1_FWD;
        sub_in_d  = letter_q;
        sub_off_d = stage_off(STG_R1_FWD, pos1_nxt, pos2_nxt, pos3_nxt);
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        letter_d = sub_out;
        if (sub_out == '0) begin
          fault_d = 1'b1;
          err_d   = 1'b1;
        end
        if (stage_q != STG_R1_INV) begin
          state_d   = ST_ISSUE;
          stage_d   = stage_q + 3'd1;
          sub_sel_d = stage_d;
          sub_in_d  = sub_out;
          sub_off_d = stage_off(stage_d, pos1_nxt, pos2_nxt, pos3_nxt);
        end else begin
          state_d      = ST_DONE;
          out_letter_d = fault_d ? letter_t'(0) : sub_out;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      stage_q      <= STG_R1_FWD;
      letter_q     <= '0;
      fault_q      <= 1'b0;
      err_q        <= 1'b0;
      key_cnt_q    <= '0;
      out_letter_q <= '0;
      sub_sel_q    <= '0;
      sub_in_q     <= '0;
      sub_off_q    <= '0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      letter_q     <= letter_d;
      fault_q      <= fault_d;
      err_q        <= err_d;
      key_cnt_q    <= key_cnt_d;
      out_letter_q <= out_letter_d;
      sub_sel_q    <= sub_sel_d;
      sub_in_q     <= sub_in_d;
      sub_off_q    <= sub_off_d;
    end
  end

  assign err        = err_q;
  assign key_cnt    = key_cnt_q;
  assign out_letter = out_letter_q;
  assign sub_sel    = sub_sel_q;
  assign sub_in     = sub_in_q;
  assign sub_off    = sub_off_q;

endmodule
